// File: rtl/reverb_template_pio_arbiter_pkg.sv
// Shared types and default widths for the two-requester PIO arbiter.
package reverb_template_pio_arb_pkg;

    localparam int DEF_ADDR_W = 2;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] address;
        logic [DEF_DATA_W-1:0] writedata;
        logic                  is_write;
    } arb_req_t;

endpackage

// File: rtl/reverb_template_pio_arbiter_if.sv
// Avalon-MM requester bus and the PIO slave bus seen by the arbiter.
interface reverb_template_pio_arbiter_if #(
    parameter int ADDR_W = reverb_template_pio_arb_pkg::DEF_ADDR_W,
    parameter int DATA_W = reverb_template_pio_arb_pkg::DEF_DATA_W
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;

    modport master (output address, read, write, writedata, input readdata, waitrequest);
    modport slave  (input address, read, write, writedata, output readdata, waitrequest);
endinterface

interface reverb_template_pio_bus_if #(
    parameter int ADDR_W = reverb_template_pio_arb_pkg::DEF_ADDR_W,
    parameter int DATA_W = reverb_template_pio_arb_pkg::DEF_DATA_W
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/reverb_template_pio_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker; on a tie the requester that was not served last wins.
module reverb_template_rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       rr_last_i,
    output logic       grant_valid_o,
    output logic       grant_idx_o
);
    assign grant_valid_o = |req_i;
    assign grant_idx_o   = (&req_i) ? ~rr_last_i : req_i[1];
endmodule

// File: rtl/reverb_template_pio_arbiter.sv
// Serialises Nios (rq0) and reverb engine (rq1) accesses onto one PIO slave, all outputs registered.
// IDLE: arbitrate and latch | ACCESS: one-cycle PIO strobe | RESP: winner's waitrequest low
module reverb_template_pio_arbiter
    import reverb_template_pio_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                          clk,
    input  logic                          reset,
    reverb_template_pio_arbiter_if.slave  rq0,
    reverb_template_pio_arbiter_if.slave  rq1,
    reverb_template_pio_bus_if.master     pio,
    output logic                          grant_id
);
    arb_state_e        state_q, state_d;
    logic              grant_q, grant_d;
    logic              rr_last_q, rr_last_d;
    logic              cs_q, cs_d;
    logic              write_n_q, write_n_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
    logic [1:0]        wait_q, wait_d;
    logic              pick_valid, pick_idx;
    arb_req_t          sel;

    reverb_template_rr_pick2 u_pick (
        .req_i         ({rq1.read | rq1.write, rq0.read | rq0.write}),
        .rr_last_i     (rr_last_q),
        .grant_valid_o (pick_valid),
        .grant_idx_o   (pick_idx)
    );

    // read+write together is a write: is_write follows the write strobe alone
    always_comb begin
        if (pick_idx) begin
            sel = '{address: rq1.address, writedata: rq1.writedata, is_write: rq1.write};
        end else begin
            sel = '{address: rq0.address, writedata: rq0.writedata, is_write: rq0.write};
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_last_d = rr_last_q;
        cs_d      = 1'b0;
        write_n_d = 1'b1;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd0_d     = rd0_q;
        rd1_d     = rd1_q;
        wait_d    = 2'b11;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d   = ACCESS;
                    grant_d   = pick_idx;
                    cs_d      = 1'b1;
                    write_n_d = ~sel.is_write;
                    addr_d    = sel.address;
                    wdata_d   = sel.writedata;
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (write_n_q) begin
                    if (grant_q) rd1_d = pio.readdata;
                    else         rd0_d = pio.readdata;
                end
                wait_d[grant_q] = 1'b0;
            end
            RESP: begin
                state_d   = IDLE;
                rr_last_d = grant_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            rr_last_q <= 1'b1;
            cs_q      <= 1'b0;
            write_n_q <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd0_q     <= '0;
            rd1_q     <= '0;
            wait_q    <= 2'b11;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_last_q <= rr_last_d;
            cs_q      <= cs_d;
            write_n_q <= write_n_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd0_q     <= rd0_d;
            rd1_q     <= rd1_d;
            wait_q    <= wait_d;
        end
    end

    assign rq0.readdata    = rd0_q;
    assign rq0.waitrequest = wait_q[0];
    assign rq1.readdata    = rd1_q;
    assign rq1.waitrequest = wait_q[1];
    assign pio.address     = addr_q;
    assign pio.chipselect  = cs_q;
    assign pio.write_n     = write_n_q;
    assign pio.writedata   = wdata_q;
    assign grant_id        = grant_q;

endmodule

// File: tb/tb_reverb_template_pio_arbiter.sv
// Bench for the PIO arbiter: directed scenarios plus random two-requester traffic against a transaction-level model.
module tb_reverb_template_pio_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic grant_id;
    logic pio_port;

    always #5 clk = ~clk;

    reverb_template_pio_arbiter_if rq0_if ();
    reverb_template_pio_arbiter_if rq1_if ();
    reverb_template_pio_bus_if     pio_if ();

    reverb_template_pio_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .rq0      (rq0_if),
        .rq1      (rq1_if),
        .pio      (pio_if),
        .grant_id (grant_id)
    );

    // Single-bit output PIO: data register at address 0, others read as zero
    always @(posedge clk or posedge reset) begin
        if (reset) pio_port <= 1'b0;
        else if (pio_if.chipselect && !pio_if.write_n && pio_if.address == 2'd0)
            pio_port <= pio_if.writedata[0];
    end
    assign pio_if.readdata = (pio_if.address == 2'd0) ? {31'b0, pio_port} : 32'b0;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Model: each grant expands into a scheduled pair of cycles (strobe, response)
    typedef struct {
        bit        idle;
        bit        cs;
        bit        wn;
        bit [1:0]  addr;
        bit [31:0] wd;
        bit [1:0]  wt;
        bit        g;
    } cyc_t;

    cyc_t      cur = '{1'b1, 1'b0, 1'b1, 2'd0, 32'd0, 2'b11, 1'b0};
    cyc_t      sched[$];
    bit        m_rr = 1'b1;
    bit [31:0] m_rd [2] = '{32'd0, 32'd0};
    bit        m_port = 1'b0;

    initial begin : model
        bit   r0, r1, g, w;
        cyc_t c;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                sched.delete();
                cur     = '{1'b1, 1'b0, 1'b1, 2'd0, 32'd0, 2'b11, 1'b0};
                m_rr    = 1'b1;
                m_rd[0] = 32'd0;
                m_rd[1] = 32'd0;
                m_port  = 1'b0;
            end else begin
                if (cur.cs && cur.wn)
                    m_rd[cur.g] = (cur.addr == 2'd0) ? {31'b0, m_port} : 32'd0;
                if (cur.cs && !cur.wn && cur.addr == 2'd0)
                    m_port = cur.wd[0];
                if (cur.idle) begin
                    r0 = rq0_if.read | rq0_if.write;
                    r1 = rq1_if.read | rq1_if.write;
                    if (r0 || r1) begin
                        g    = (r0 && r1) ? !m_rr : r1;
                        m_rr = g;
                        w    = g ? rq1_if.write : rq0_if.write;
                        c.idle = 1'b0;
                        c.cs   = 1'b1;
                        c.wn   = !w;
                        c.addr = g ? rq1_if.address : rq0_if.address;
                        c.wd   = g ? rq1_if.writedata : rq0_if.writedata;
                        c.wt   = 2'b11;
                        c.g    = g;
                        sched.push_back(c);
                        c.cs = 1'b0;
                        c.wn = 1'b1;
                        c.wt = g ? 2'b01 : 2'b10;
                        sched.push_back(c);
                    end
                end
                if (sched.size() > 0) cur = sched.pop_front();
                else cur = '{1'b1, 1'b0, 1'b1, cur.addr, cur.wd, 2'b11, cur.g};
            end
        end
    end

    initial begin : compare
        logic prev_cs;
        prev_cs = 1'b0;
        forever begin
            @(negedge clk);
            chk("pio_chipselect", pio_if.chipselect, cur.cs);
            chk("pio_write_n", pio_if.write_n, cur.wn);
            chk("pio_address", pio_if.address, cur.addr);
            chk("pio_writedata", pio_if.writedata, cur.wd);
            chk("rq0_waitrequest", rq0_if.waitrequest, cur.wt[0]);
            chk("rq1_waitrequest", rq1_if.waitrequest, cur.wt[1]);
            chk("rq0_readdata", rq0_if.readdata, m_rd[0]);
            chk("rq1_readdata", rq1_if.readdata, m_rd[1]);
            chk("grant_id", grant_id, cur.g);
            chk("pio_port", pio_port, m_port);
            chk("cs_back_to_back", prev_cs & pio_if.chipselect, 1'b0);
            chk("both_wait_low", !rq0_if.waitrequest && !rq1_if.waitrequest, 1'b0);
            prev_cs = pio_if.chipselect;
        end
    end

    task automatic drive(input int id, input bit r, input bit w, input logic [1:0] a, input logic [31:0] d);
        if (id == 0) begin
            rq0_if.read = r; rq0_if.write = w; rq0_if.address = a; rq0_if.writedata = d;
        end else begin
            rq1_if.read = r; rq1_if.write = w; rq1_if.address = a; rq1_if.writedata = d;
        end
    endtask

    function automatic logic get_wait(input int id);
        return (id == 0) ? rq0_if.waitrequest : rq1_if.waitrequest;
    endfunction

    function automatic logic [31:0] get_rd(input int id);
        return (id == 0) ? rq0_if.readdata : rq1_if.readdata;
    endfunction

    // One complete transfer; s_* are the bus values in the cycle before completion (the strobe)
    task automatic run_req(input int id, input bit r, input bit w, input logic [1:0] a,
                           input logic [31:0] d, output logic [31:0] rdata, output int lat,
                           output logic s_cs, output logic s_wn, output logic s_gid);
        bit done;
        done = 1'b0; lat = 0; rdata = '0; s_cs = 1'b0; s_wn = 1'b1; s_gid = 1'b0;
        drive(id, r, w, a, d);
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            if (get_wait(id) == 1'b0) begin
                done = 1'b1; lat = k; rdata = get_rd(id);
            end else begin
                s_cs = pio_if.chipselect; s_wn = pio_if.write_n; s_gid = grant_id;
            end
        end
        chk($sformatf("completion_rq%0d", id), done, 1'b1);
        @(posedge clk);
        #1 drive(id, 1'b0, 1'b0, a, d);
    endtask

    int order[$];

    task automatic rand_traffic(input int id, input int n);
        logic [31:0] rdata;
        int lat, op;
        logic s_cs, s_wn, s_gid;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            op = $urandom_range(0, 2);
            run_req(id, op != 1, op != 0, 2'($urandom_range(0, 3)), $urandom, rdata, lat, s_cs, s_wn, s_gid);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        logic [31:0] rdata;
        int lat;
        logic s_cs, s_wn, s_gid;
        bit ok;
        drive(0, 1'b0, 1'b0, 2'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 2'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rq0_wait", rq0_if.waitrequest, 1'b1);
        chk("rst_rq1_wait", rq1_if.waitrequest, 1'b1);
        chk("rst_cs", pio_if.chipselect, 1'b0);
        chk("rst_write_n", pio_if.write_n, 1'b1);
        chk("rst_grant", grant_id, 1'b0);
        chk("rst_rq0_rd", rq0_if.readdata, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        run_req(0, 1'b0, 1'b1, 2'd0, 32'h1, rdata, lat, s_cs, s_wn, s_gid);
        chk("wr_latency", lat, 3);
        chk("wr_strobe_cs", s_cs, 1'b1);
        chk("wr_strobe_wn", s_wn, 1'b0);
        chk("wr_port", pio_port, 1'b1);
        @(negedge clk);
        chk("wr_wait_one_cycle", rq0_if.waitrequest, 1'b1);
        @(posedge clk);
        #1;

        run_req(1, 1'b1, 1'b0, 2'd0, 32'd0, rdata, lat, s_cs, s_wn, s_gid);
        chk("rd_addr0", rdata, 32'h1);
        chk("rd_strobe_wn", s_wn, 1'b1);
        run_req(1, 1'b1, 1'b0, 2'd1, 32'd0, rdata, lat, s_cs, s_wn, s_gid);
        chk("rd_addr1", rdata, 32'h0);

        fork
            begin
                logic [31:0] rd_a; int lat_a; logic c_a, w_a, g_a;
                for (int i = 0; i < 4; i++) begin
                    run_req(0, 1'b0, 1'b1, 2'd0, 32'h0, rd_a, lat_a, c_a, w_a, g_a);
                    order.push_back(0);
                end
            end
            begin
                logic [31:0] rd_b; int lat_b; logic c_b, w_b, g_b;
                for (int i = 0; i < 4; i++) begin
                    run_req(1, 1'b0, 1'b1, 2'd0, 32'h1, rd_b, lat_b, c_b, w_b, g_b);
                    order.push_back(1);
                end
            end
        join
        chk("rr_count", order.size(), 8);
        for (int i = 0; i < order.size(); i++) chk($sformatf("rr_order_%0d", i), order[i], i % 2);
        chk("rr_final_port", pio_port, 1'b1);

        run_req(0, 1'b1, 1'b0, 2'd0, 32'd0, rdata, lat, s_cs, s_wn, s_gid);
        chk("rq0_rd_port", rdata, 32'h1);
        run_req(0, 1'b1, 1'b1, 2'd0, 32'h0, rdata, lat, s_cs, s_wn, s_gid);
        chk("rw_is_write", s_wn, 1'b0);
        chk("rw_rd_kept", rq0_if.readdata, 32'h1);
        chk("rw_port", pio_port, 1'b0);

        drive(0, 1'b0, 1'b1, 2'd1, 32'h5);
        drive(1, 1'b0, 1'b1, 2'd2, 32'h7);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_cs", pio_if.chipselect, 1'b0);
        chk("arst_write_n", pio_if.write_n, 1'b1);
        chk("arst_grant", grant_id, 1'b0);
        chk("arst_addr", pio_if.address, 2'd0);
        chk("arst_wdata", pio_if.writedata, 32'd0);
        chk("arst_rq0_rd", rq0_if.readdata, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("regrant_cs", pio_if.chipselect, 1'b1);
        chk("regrant_id", grant_id, 1'b0);
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = !rq0_if.waitrequest;
        end
        chk("regrant_rq0_done", ok, 1'b1);
        @(posedge clk);
        #1 drive(0, 1'b0, 1'b0, 2'd0, 32'd0);
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = !rq1_if.waitrequest;
        end
        chk("regrant_rq1_done", ok, 1'b1);
        @(posedge clk);
        #1 drive(1, 1'b0, 1'b0, 2'd0, 32'd0);

        fork
            rand_traffic(0, 60);
            rand_traffic(1, 60);
        join
        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reverb_template_pio_arbiter.md
Name: reverb_template_pio_arbiter

Overview:
- Two-requester Avalon-MM arbiter in front of one single-bit output PIO slave (2-bit address, 32-bit data, combinational readdata, write takes effect on the clock edge).
- Requester 0 is the Nios data master and requester 1 is the reverb hardware engine. Both drive the same PIO register, for example a bypass/mute control.
- Serialises accesses with round-robin fairness and returns registered read data with a waitrequest handshake.

Parameters:
- ADDR_W, 2, PIO address width.
- DATA_W, 32, data width on all ports.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rq0_address  in  ADDR_W  requester 0 word address
- rq0_read  in  1  requester 0 read request
- rq0_write  in  1  requester 0 write request
- rq0_writedata  in  DATA_W  requester 0 write data
- rq0_readdata  out  DATA_W  requester 0 read data, valid when rq0_waitrequest=0 for a read
- rq0_waitrequest  out  1  requester 0 stall
- rq1_address, rq1_read, rq1_write, rq1_writedata, rq1_readdata, rq1_waitrequest: same as rq0_*, for requester 1
- pio_address  out  ADDR_W  to PIO address
- pio_chipselect  out  1  to PIO chipselect
- pio_write_n  out  1  to PIO write_n, active-low
- pio_writedata  out  DATA_W  to PIO writedata
- pio_readdata  in  DATA_W  from PIO readdata
- grant_id  out  1  index of the requester currently or most recently granted (debug)

Behaviour:
- Reset values: rqX_waitrequest=1, rqX_readdata=0, pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0, grant_id=0, FSM=IDLE, rr_last=1 (so requester 0 wins the first tie).
- Requester protocol:
  - Requester asserts read or write with address and data, and holds them stable until it samples waitrequest=0.
  - rqX_waitrequest is 1 in every cycle except that requester's RESP cycle, including while idle.
  - read and write asserted together is treated as a write.
- FSM, all outputs registered:
  - IDLE: if any request is pending, select the requester. If both are pending, pick the one != rr_last; otherwise pick the one requesting. Latch address, data and op; set grant_id; go to ACCESS.
  - ACCESS (exactly 1 cycle): pio_chipselect=1, pio_address=latched address, pio_write_n=0 for a write (1 for a read), pio_writedata=latched data. At the end of the cycle, capture pio_readdata into the granted rqX_readdata for a read; a write leaves rqX_readdata unchanged. Go to RESP.
  - RESP (1 cycle): pio_chipselect=0, pio_write_n=1; granted rqX_waitrequest=0; rr_last<=grant. Go to IDLE.
- Latency: request sampled in IDLE at cycle N → PIO strobe in cycle N+1 → waitrequest low in cycle N+2. Throughput is one transfer per 3 cycles.
- Fairness:
  - Under continuous contention, grants alternate 0,1,0,1.
  - A lone requester is granted back-to-back with no penalty.
- Request withdrawn before grant (protocol violation): ignored if not present in the IDLE sample cycle; no access is issued.
- A new request asserted during ACCESS or RESP waits for the next IDLE; nothing is buffered.
- Reset mid-operation: any state returns to IDLE immediately and all outputs take their reset values. A write already strobed in ACCESS may have reached the PIO; the requester gets no completion and must retry.
- No PIO write is ever issued outside ACCESS; pio_chipselect is never high for two consecutive cycles.

Decomposition:
- Shared package reverb_template_pio_arb_pkg: FSM state enum {IDLE, ACCESS, RESP}, a request struct (address, writedata, is_write), and ADDR_W/DATA_W defaults.
- One natural sub-module: reverb_template_rr_pick2. Combinational 2-way round-robin picker: inputs req[1:0] and rr_last; outputs grant_valid and grant_idx.

Test Plan:
- Reset, then rq0 writes 0x1 to address 0 → pio_chipselect=1 and pio_write_n=0 in cycle 2; rq0_waitrequest=0 in cycle 3 only; PIO out_port=1 afterwards.
- rq1 reads address 0 after PIO holds 1 → rq1_readdata=0x00000001 with rq1_waitrequest=0. Read of address 1 → rq1_readdata=0x00000000.
- rq0 and rq1 both write continuously (0x0 and 0x1) for 8 transfers → grant_id sequence 0,1,0,1,…; final PIO value is that of the last grant; each requester completes 4 transfers.
- Same cycle read+write from rq0 → treated as a write: pio_write_n=0; no spurious read data update.
- reset asserted during ACCESS → outputs at reset values in the same cycle (async); FSM in IDLE; a held request is re-granted after release, with requester 0 winning a tie.
- Assertions across a random-traffic run: pio_chipselect never high in two consecutive cycles; both waitrequests never low in the same cycle.
